imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Arbitrates the single-port instruction memory between the CPU instruction fetch path and the UART program loader. In run mode the fetch path owns the port. In program mode the CPU is stalled, incoming bytes are packed into 32-bit words and written sequentially from word 0. On leaving program mode, a CPU restart pulse is issued so the PC fetches the new image from address 0.

## Interface
Parameters:
- ADDR_W, 14, instruction memory word-address width (depth 2^ADDR_W words)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- prog_mode  in  1  1 = program mode requested (board switch, already synchronised)
- fetch_req  in  1  fetch path requests a read this cycle
- fetch_addr  in  32  byte address (PC); bits [ADDR_W+1:2] are used
- fetch_data  out  32  read word, valid when fetch_valid=1
- fetch_valid  out  1  fetch_data valid (one cycle after accepted fetch_req)
- cpu_stall  out  1  holds PC/register writes while not in RUN
- cpu_restart  out  1  one-cycle pulse; CPU resets PC to 0
- load_valid  in  1  loader byte present
- load_byte  in  8  loader data byte
- load_ready  out  1  arbiter accepts a byte this cycle
- load_words  out  ADDR_W+1  words written in the current/last program session
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory read data, synchronous (1-cycle latency)
- checksum  out  32  wrapping sum of written words (see Configuration)

## Operation
- States: RUN, LOAD, WRITE, FLUSH, RESTART.
- RUN: mem_addr = fetch_addr[ADDR_W+1:2], mem_we=0, cpu_stall=0, load_ready=0. If fetch_req=1, fetch_valid=1 next cycle with fetch_data=mem_rdata. If prog_mode=1, go to LOAD; load_words, byte index and word pointer clear to 0.
- LOAD: cpu_stall=1, load_ready=1. Byte handshake on load_valid & load_ready. Bytes are packed little-endian (first byte → [7:0]). After the 4th byte, go to WRITE. If prog_mode=0 and no byte is accepted this cycle, go to FLUSH. A byte accepted in the same cycle prog_mode falls is kept, then FLUSH follows (or WRITE, if it was the 4th byte).
- WRITE: mem_we=1, mem_addr=word pointer, mem_wdata=assembled word. Then word pointer+1 and load_words+1. Go to LOAD if prog_mode=1, else RESTART. load_ready=0.
- FLUSH: if 1–3 bytes are pending, perform one write with the unused upper bytes zero, and load_words+1. If 0 are pending, no write. Then go to RESTART.
- RESTART: cpu_restart=1 for exactly one cycle, cpu_stall=1. Then go to RUN.
- Word pointer is ADDR_W bits and wraps 2^ADDR_W−1 → 0. load_words saturates at 2^ADDR_W.
- fetch_valid is 0 in every state except RUN. A fetch accepted in the cycle RUN→LOAD produces no fetch_valid.

## Timing
- Reset (async) values:
  - state RUN
  - fetch_valid=0, cpu_stall=0, cpu_restart=0, load_ready=0, mem_we=0
  - load_words=0, checksum=0, internal byte index/pointer=0
- Fetch latency: 1 cycle, fully pipelined; back-to-back fetch_req gives back-to-back fetch_valid.
- Byte throughput: 4 bytes per 5 cycles max (LOAD×4, WRITE×1).
- prog_mode rise → cpu_stall=1 on the next cycle.
- prog_mode fall → cpu_restart after at most 2 cycles (FLUSH/WRITE, RESTART) once LOAD observes it.
- rst asserted mid-session drops everything immediately. Partially assembled bytes are lost. No write or restart pulse is issued.

## Configuration
- IMEM_ARB_CHECKSUM_EN defined: checksum accumulates the 32-bit wrapping sum of every mem_wdata written while mem_we=1. It clears on entry to LOAD and holds in RUN.
- IMEM_ARB_CHECKSUM_EN undefined: checksum is tied to 32'h0 and no accumulator register exists.

## Test plan
- Reset then fetch_req with fetch_addr=0x8, memory word 2=0x2010_0005 → next cycle fetch_valid=1, fetch_data=0x2010_0005; cpu_stall=0.
- prog_mode=1, bytes 0x78,0x56,0x34,0x12 → one mem_we pulse at addr 0 with data 0x1234_5678; load_words=1; load_ready=0 during WRITE.
- 6 bytes 0x01..0x06 then prog_mode=0 → writes 0x0403_0201 @0 and 0x0000_0605 @1. Single cpu_restart pulse follows; load_words=2; return to RUN.
- prog_mode fall with 0 pending bytes → no FLUSH write; cpu_restart exactly one cycle later.
- rst pulse after 2 bytes in LOAD → no mem_we; state RUN, outputs at reset values.
- With IMEM_ARB_CHECKSUM_EN, words 0xFFFF_FFFF and 0x0000_0002 → checksum=0x0000_0001. Without the macro, checksum=0 throughout.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single-port instruction memory between the CPU fetch path and
// the UART program loader. Run mode: fetch owns the port. Program mode: the
// CPU is stalled, loader bytes are packed little-endian into 32-bit words and
// written sequentially from word 0. Leaving program mode flushes any partial
// word and issues a one-cycle CPU restart pulse.
//
// Optional feature macro: IMEM_ARB_CHECKSUM_EN
//   defined   -> checksum accumulates the wrapping sum of written words
//   undefined -> checksum is tied to zero, no accumulator exists
module imem_port_arbiter #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_mode,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic [31:0]       fetch_data,
   output logic              fetch_valid,
   output logic              cpu_stall,
   output logic              cpu_restart,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   output logic              load_ready,
   output logic [ADDR_W:0]   load_words,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       checksum
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W:0] L_WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_LOAD    = 3'd1,
      S_WRITE   = 3'd2,
      S_FLUSH   = 3'd3,
      S_RESTART = 3'd4
   } state_t;

   state_t              r_state;
   logic [1:0]          r_byte_idx;
   logic [31:0]         r_word;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W:0]     r_load_words;
   logic                r_fetch_valid;

   logic                w_accept;
   logic                w_flush_we;
   logic                w_we;
   logic                w_session_start;
   logic [ADDR_W:0]     w_words_next;
   logic                w_unused_fetch_bits;

   // Byte handshake, memory write strobes and saturating word count
   assign w_accept        = (r_state == S_LOAD) && load_valid;
   assign w_flush_we      = (r_state == S_FLUSH) && (r_byte_idx != 2'd0);
   assign w_we            = (r_state == S_WRITE) || w_flush_we;
   assign w_session_start = (r_state == S_RUN) && prog_mode;
   assign w_words_next    = (r_load_words == L_WORDS_MAX) ? r_load_words
                                                          : r_load_words + CNT_W'(1);
   assign w_unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

   // Arbiter FSM with byte packing, word pointer and word counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_RUN;
         r_byte_idx    <= 2'd0;
         r_word        <= 32'd0;
         r_ptr         <= '0;
         r_load_words  <= '0;
         r_fetch_valid <= 1'b0;
      end else begin
         // A fetch issued as program mode begins is dropped
         r_fetch_valid <= (r_state == S_RUN) && fetch_req && !prog_mode;
         case (r_state)
            S_RUN: begin
               if (prog_mode) begin
                  r_state      <= S_LOAD;
                  r_byte_idx   <= 2'd0;
                  r_word       <= 32'd0;
                  r_ptr        <= '0;
                  r_load_words <= '0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_word[{r_byte_idx, 3'b000} +: 8] <= load_byte;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_state <= S_WRITE;
                  end else if (!prog_mode) begin
                     r_state <= S_FLUSH;
                  end
               end else if (!prog_mode) begin
                  r_state <= S_FLUSH;
               end
            end
            S_WRITE: begin
               r_ptr        <= r_ptr + ADDR_W'(1);
               r_load_words <= w_words_next;
               r_word       <= 32'd0;
               r_state      <= prog_mode ? S_LOAD : S_RESTART;
            end
            S_FLUSH: begin
               if (w_flush_we) begin
                  r_ptr        <= r_ptr + ADDR_W'(1);
                  r_load_words <= w_words_next;
                  r_byte_idx   <= 2'd0;
                  r_word       <= 32'd0;
               end
               r_state <= S_RESTART;
            end
            S_RESTART: begin
               r_state <= S_RUN;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

`ifdef IMEM_ARB_CHECKSUM_EN
   logic [31:0] r_checksum;

   // Wrapping sum of written words, cleared at the start of each session
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_checksum <= 32'd0;
      end else if (w_session_start) begin
         r_checksum <= 32'd0;
      end else if (w_we) begin
         r_checksum <= r_checksum + r_word;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = 32'd0;
`endif

   // Port decode: fetch owns the address in RUN, loader pointer otherwise
   assign mem_addr    = (r_state == S_RUN) ? fetch_addr[ADDR_W+1:2] : r_ptr;
   assign mem_wdata   = r_word;
   assign mem_we      = w_we;
   assign fetch_data  = mem_rdata;
   assign fetch_valid = r_fetch_valid;
   assign cpu_stall   = (r_state != S_RUN);
   assign cpu_restart = (r_state == S_RESTART);
   assign load_ready  = (r_state == S_LOAD);
   assign load_words  = r_load_words;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_imem_port_arbiter;

   localparam int unsigned AW = 6;
   localparam int unsigned D  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          prog_mode = 1'b0;
   logic          fetch_req = 1'b0;
   logic [31:0]   fetch_addr = 32'd0;
   logic [31:0]   fetch_data;
   logic          fetch_valid;
   logic          cpu_stall;
   logic          cpu_restart;
   logic          load_valid = 1'b0;
   logic [7:0]    load_byte = 8'd0;
   logic          load_ready;
   logic [AW:0]   load_words;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_we;
   logic [31:0]   mem_rdata;
   logic [31:0]   checksum;

   int n_checks = 0;
   int n_errors = 0;

   // Memory image the DUT writes, and the image the model says it should hold
   logic [31:0] env_mem [0:D-1];
   logic [31:0] ref_mem [0:D-1];

   // Reference model: run/session flags, pending bytes, pointer, counters
   bit          m_run, m_fv, m_wr, m_fl, m_rs;
   int          m_pend, m_ptr, m_words;
   logic [31:0] m_word, m_sum, m_fd;

   always #5 clk = ~clk;

   imem_port_arbiter #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .prog_mode(prog_mode),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_data(fetch_data), .fetch_valid(fetch_valid),
      .cpu_stall(cpu_stall), .cpu_restart(cpu_restart),
      .load_valid(load_valid), .load_byte(load_byte), .load_ready(load_ready),
      .load_words(load_words), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .checksum(checksum)
   );

   // Synchronous single-port memory, one-cycle read latency
   always @(posedge clk) begin
      mem_rdata <= env_mem[mem_addr];
      if (mem_we) env_mem[mem_addr] = mem_wdata;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_checksum();
`ifdef IMEM_ARB_CHECKSUM_EN
      return m_sum;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      m_run = 1'b1; m_fv = 1'b0; m_wr = 1'b0; m_fl = 1'b0; m_rs = 1'b0;
      m_pend = 0; m_ptr = 0; m_words = 0; m_word = 32'd0; m_sum = 32'd0; m_fd = 32'd0;
   endtask

   task automatic model_write();
      ref_mem[m_ptr] = m_word;
      m_ptr   = (m_ptr + 1) % D;
      m_words = (m_words < D) ? m_words + 1 : m_words;
      m_sum   = m_sum + m_word;
      m_pend  = 0;
      m_word  = 32'd0;
   endtask

   // One clock: drive inputs, compare outputs with the model, advance the model
   task automatic cycle(input logic pm, input logic fr, input logic [31:0] fa,
                        input logic lv, input logic [7:0] lb);
      bit e_ready, e_we, cont;
      @(negedge clk);
      prog_mode = pm; fetch_req = fr; fetch_addr = fa; load_valid = lv; load_byte = lb;
      #1;
      e_ready = !m_run && !m_wr && !m_fl && !m_rs;
      e_we    = m_wr || (m_fl && m_pend > 0);
      check_val("cpu_stall",   32'(cpu_stall),   32'(!m_run));
      check_val("load_ready",  32'(load_ready),  32'(e_ready));
      check_val("mem_we",      32'(mem_we),      32'(e_we));
      check_val("cpu_restart", 32'(cpu_restart), 32'(m_rs));
      check_val("fetch_valid", 32'(fetch_valid), 32'(m_fv));
      if (m_fv) check_val("fetch_data", fetch_data, m_fd);
      if (e_we) begin
         check_val("mem_addr",  32'(mem_addr), 32'(m_ptr));
         check_val("mem_wdata", mem_wdata, m_word);
      end
      check_val("load_words", 32'(load_words), 32'(m_words));
      check_val("checksum",   checksum, exp_checksum());
      if (m_run) begin
         m_fv = fr && !pm;
         m_fd = ref_mem[fa[AW+1:2]];
         if (pm) begin
            m_run = 1'b0; m_pend = 0; m_word = 32'd0; m_ptr = 0; m_words = 0; m_sum = 32'd0;
         end
      end else begin
         m_fv = 1'b0;
         if (m_rs) begin
            m_rs = 1'b0; m_run = 1'b1;
         end else if (m_wr || m_fl) begin
            if (e_we) model_write();
            cont = m_wr && pm;
            m_wr = 1'b0; m_fl = 1'b0;
            if (!cont) m_rs = 1'b1;
         end else if (lv && e_ready) begin
            m_word = m_word | (32'(lb) << (8 * m_pend));
            m_pend++;
            if (m_pend == 4) m_wr = 1'b1;
            else if (!pm) m_fl = 1'b1;
         end else if (!pm) begin
            m_fl = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 8'd0);
   endtask

   task automatic load_byte_cycle(input logic [7:0] b);
      cycle(1'b1, 1'b0, 32'd0, 1'b1, b);
   endtask

   // Asynchronous reset mid-cycle: outputs must drop at once
   task automatic do_reset();
      @(negedge clk);
      prog_mode = 1'b0; fetch_req = 1'b0; load_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_val("rst_mem_we",      32'(mem_we),      32'd0);
      check_val("rst_cpu_stall",   32'(cpu_stall),   32'd0);
      check_val("rst_cpu_restart", 32'(cpu_restart), 32'd0);
      check_val("rst_load_ready",  32'(load_ready),  32'd0);
      check_val("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check_val("rst_load_words",  32'(load_words),  32'd0);
      check_val("rst_checksum",    checksum,         32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [7:0] bseq [0:7];
      logic       pm_r;
      for (int i = 0; i < D; i++) begin
         env_mem[i] = $urandom;
         ref_mem[i] = env_mem[i];
      end
      env_mem[2] = 32'h2010_0005;
      ref_mem[2] = 32'h2010_0005;
      model_reset();

      // Power-on reset values
      #3;
      check_val("por_cpu_stall",   32'(cpu_stall),   32'd0);
      check_val("por_load_ready",  32'(load_ready),  32'd0);
      check_val("por_mem_we",      32'(mem_we),      32'd0);
      check_val("por_cpu_restart", 32'(cpu_restart), 32'd0);
      check_val("por_fetch_valid", 32'(fetch_valid), 32'd0);
      check_val("por_load_words",  32'(load_words),  32'd0);
      check_val("por_checksum",    checksum,         32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Fetch of word 2 returns its content one cycle later
      cycle(1'b0, 1'b1, 32'h0000_0008, 1'b0, 8'd0);
      @(posedge clk); #1;
      check_val("fetch_w2_valid", 32'(fetch_valid), 32'd1);
      check_val("fetch_w2_data",  fetch_data, 32'h2010_0005);
      check_val("fetch_w2_stall", 32'(cpu_stall), 32'd0);
      idle(2);

      // One full word
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      bseq[0] = 8'h78; bseq[1] = 8'h56; bseq[2] = 8'h34; bseq[3] = 8'h12;
      for (int i = 0; i < 4; i++) load_byte_cycle(bseq[i]);
      cycle(1'b1, 1'b0, 32'd0, 1'b1, 8'hEE);
      idle(5);
      check_val("word0_image", env_mem[0], 32'h1234_5678);
      check_val("word0_count", 32'(load_words), 32'd1);

      // Six bytes then leave: one full word and a zero-padded partial word
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) load_byte_cycle(8'(i + 1));
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      load_byte_cycle(8'h05);
      load_byte_cycle(8'h06);
      idle(5);
      check_val("six_w0",    env_mem[0], 32'h0403_0201);
      check_val("six_w1",    env_mem[1], 32'h0000_0605);
      check_val("six_count", 32'(load_words), 32'd2);

      // Leave with nothing pending: FLUSH without a write, then restart
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) load_byte_cycle(8'hA0 + 8'(i));
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      idle(5);
      check_val("nopend_count", 32'(load_words), 32'd1);

      // Reset after two bytes: nothing written, everything back to idle
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      load_byte_cycle(8'h11);
      load_byte_cycle(8'h22);
      do_reset();
      check_val("rst_no_write", env_mem[0], ref_mem[0]);
      idle(3);

      // Checksum wraps: FFFF_FFFF + 0000_0002
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) load_byte_cycle(8'hFF);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      bseq[4] = 8'h02; bseq[5] = 8'h00; bseq[6] = 8'h00; bseq[7] = 8'h00;
      for (int i = 4; i < 8; i++) load_byte_cycle(bseq[i]);
      idle(5);
`ifdef IMEM_ARB_CHECKSUM_EN
      check_val("checksum_wrap", checksum, 32'h0000_0001);
`else
      check_val("checksum_off", checksum, 32'h0000_0000);
`endif

      // Long session: pointer wraps past the last word, count saturates
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
      for (int i = 0; i < 360; i++) load_byte_cycle(8'($urandom));
      idle(6);
      check_val("sat_count", 32'(load_words), 32'(D));

      // Randomized traffic with occasional program sessions and a reset
      pm_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) pm_r = !pm_r;
         if (i == 1500) do_reset();
         cycle(pm_r, 1'($urandom), $urandom, ($urandom_range(0, 3) != 0), 8'($urandom));
      end
      idle(6);

      // Final image comparison
      for (int i = 0; i < D; i++) check_val("image", env_mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
